// File: rtl/laser_lane_receiver.sv
// Oversampling serial receiver for an on/off-keyed laser lane.
// Frames are: start high, 8 data bits LSB first, stop low.
module laser_lane_receiver #(
    parameter int OVERSAMPLE = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       laser_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_LOW
    } state_t;

    state_t state;
    state_t state_nx;

    logic          sync_a;
    logic          rx;
    logic          rx_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_hit;
    logic          valid_nx;
    logic          error_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            rx     <= 1'b0;
            rx_d   <= 1'b0;
        end else begin
            sync_a <= laser_in;
            rx     <= sync_a;
            rx_d   <= rx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx && !rx_d) state_nx = START;
                end
                START: begin
                    if (cnt == HALF) state_nx = rx ? DATA : IDLE;
                end
                DATA: begin
                    if (cnt == FULL && bit_idx == 3'd7) state_nx = STOP;
                end
                STOP: begin
                    if (cnt == FULL) state_nx = rx ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!rx) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        stop_hit = en && (state == STOP) && (cnt == FULL);
        valid_nx = stop_hit && !rx;
        error_nx = stop_hit && rx;
    end

    // Result pulses are registered, so they appear the cycle after the stop sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else if (!en) begin
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= valid_nx;
            frame_error <= error_nx;
            if (valid_nx) data_out <= shreg;
            unique case (state)
                START: begin
                    cnt     <= (cnt == HALF) ? '0 : cnt + 1'b1;
                    bit_idx <= 3'd0;
                end
                DATA: begin
                    if (cnt == FULL) begin
                        shreg[bit_idx] <= rx;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    cnt <= (cnt == FULL) ? '0 : cnt + 1'b1;
                end
                default: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_lane_receiver.sv
// Directed bench for laser_lane_receiver at OVERSAMPLE=8.
// Inputs change on negedge; outputs are observed on negedge.
module tb_laser_lane_receiver;

    localparam int OV = 8;

    logic       clock;
    logic       reset;
    logic       en;
    logic       laser_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int checks;
    int failures;
    int cyc;
    int dv_cnt;
    int fe_cnt;
    int dv_cyc;
    int both_cnt;

    laser_lane_receiver #(.OVERSAMPLE(OV)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .laser_in   (laser_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: records how many result pulses occurred and when.
    always @(negedge clock) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (data_valid && frame_error) both_cnt = both_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic v);
        laser_in = v;
        repeat (OV) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v,
                             input int stop_len);
        drive_bit(1'b1);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        for (int i = 0; i < stop_len; i++) drive_bit(stop_v);
    endtask

    task automatic test_reset;
        checks++;
        if ({data_out, data_valid, frame_error, busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=000",
                     {data_out, data_valid, frame_error, busy});
        end
        reset = 1'b0;
        wait_cycles(5);
        checks++;
        if ({data_out, data_valid, frame_error, busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_release got=%h exp=000",
                     {data_out, data_valid, frame_error, busy});
        end
    endtask

    task automatic test_frame_error;
        int n0;
        int f0;
        n0 = dv_cnt;
        f0 = fe_cnt;
        send_byte(8'h08, 1'b1, 3);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr_wait_low_busy got=%b exp=1", busy);
        end
        laser_in = 1'b0;
        wait_cycles(2 * OV);
        checks++;
        if (fe_cnt !== f0 + 1) begin
            failures++;
            $display("FAIL ferr_pulses got=%0d exp=%0d", fe_cnt - f0, 1);
        end
        checks++;
        if (dv_cnt !== n0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL ferr_no_data got=%0d/%h exp=0/00",
                     dv_cnt - n0, data_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_idle_busy got=%b exp=0", busy);
        end
        send_byte(8'h17, 1'b0, 1);
        wait_cycles(2);
        checks++;
        if (dv_cnt !== n0 + 1 || data_out !== 8'h17) begin
            failures++;
            $display("FAIL ferr_recover got=%0d/%h exp=1/17",
                     dv_cnt - n0, data_out);
        end
    endtask

    task automatic test_single;
        int n0;
        int f0;
        int c0;
        n0 = dv_cnt;
        f0 = fe_cnt;
        wait_cycles(OV);
        c0 = cyc;
        send_byte(8'h17, 1'b0, 1);
        wait_cycles(2);
        checks++;
        if (dv_cnt !== n0 + 1 || data_out !== 8'h17) begin
            failures++;
            $display("FAIL single_data got=%0d/%h exp=1/17",
                     dv_cnt - n0, data_out);
        end
        checks++;
        if (dv_cyc !== c0 + 79) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=%0d", dv_cyc - c0, 79);
        end
        checks++;
        if (fe_cnt !== f0) begin
            failures++;
            $display("FAIL single_no_ferr got=%0d exp=0", fe_cnt - f0);
        end
    endtask

    task automatic test_back_to_back;
        int n0;
        int c0;
        n0 = dv_cnt;
        wait_cycles(OV);
        c0 = cyc;
        send_byte(8'hA5, 1'b0, 1);
        checks++;
        if (dv_cnt !== n0 + 1 || data_out !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_first got=%0d/%h exp=1/a5",
                     dv_cnt - n0, data_out);
        end
        send_byte(8'h5A, 1'b0, 1);
        wait_cycles(2);
        checks++;
        if (dv_cnt !== n0 + 2 || data_out !== 8'h5A) begin
            failures++;
            $display("FAIL b2b_second got=%0d/%h exp=2/5a",
                     dv_cnt - n0, data_out);
        end
        checks++;
        if (dv_cyc !== c0 + 80 + 79) begin
            failures++;
            $display("FAIL b2b_latency got=%0d exp=%0d", dv_cyc - c0, 159);
        end
    endtask

    task automatic test_glitch;
        int n0;
        int f0;
        int bc;
        n0 = dv_cnt;
        f0 = fe_cnt;
        bc = 0;
        wait_cycles(OV);
        laser_in = 1'b1;
        wait_cycles(2);
        laser_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy) bc++;
        end
        checks++;
        if (bc !== OV / 2) begin
            failures++;
            $display("FAIL glitch_busy_cycles got=%0d exp=%0d", bc, OV / 2);
        end
        checks++;
        if (dv_cnt !== n0 || fe_cnt !== f0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_no_pulse got=%0d/%0d/%b exp=0/0/0",
                     dv_cnt - n0, fe_cnt - f0, busy);
        end
    endtask

    task automatic test_reset_midframe;
        int n0;
        wait_cycles(OV);
        drive_bit(1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        laser_in = 1'b1;
        wait_cycles(3);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy_before got=%b exp=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, frame_error, busy} !== 11'h000) begin
            failures++;
            $display("FAIL rstmid_async got=%h exp=000",
                     {data_out, data_valid, frame_error, busy});
        end
        laser_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        wait_cycles(10);
        n0 = dv_cnt;
        send_byte(8'h3C, 1'b0, 1);
        wait_cycles(2);
        checks++;
        if (dv_cnt !== n0 + 1 || data_out !== 8'h3C) begin
            failures++;
            $display("FAIL rstmid_next got=%0d/%h exp=1/3c",
                     dv_cnt - n0, data_out);
        end
    endtask

    task automatic test_enable_drop;
        int n0;
        int f0;
        n0 = dv_cnt;
        f0 = fe_cnt;
        wait_cycles(OV);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        laser_in = 1'b1;
        wait_cycles(3);
        en = 1'b0;
        laser_in = 1'b0;
        wait_cycles(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL endrop_busy got=%b exp=0", busy);
        end
        wait_cycles(18);
        en = 1'b1;
        checks++;
        if (data_out !== 8'h3C || dv_cnt !== n0 || fe_cnt !== f0) begin
            failures++;
            $display("FAIL endrop_hold got=%h/%0d/%0d exp=3c/0/0",
                     data_out, dv_cnt - n0, fe_cnt - f0);
        end
        wait_cycles(5);
        send_byte(8'h55, 1'b0, 1);
        wait_cycles(2);
        checks++;
        if (dv_cnt !== n0 + 1 || data_out !== 8'h55) begin
            failures++;
            $display("FAIL endrop_next got=%0d/%h exp=1/55",
                     dv_cnt - n0, data_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        dv_cnt   = 0;
        fe_cnt   = 0;
        dv_cyc   = 0;
        both_cnt = 0;
        reset    = 1'b1;
        en       = 1'b1;
        laser_in = 1'b0;
        wait_cycles(3);
        test_reset;
        test_frame_error;
        test_single;
        test_back_to_back;
        test_glitch;
        test_reset_midframe;
        test_enable_drop;
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL pulse_overlap got=%0d exp=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
